program_loader: RTL
===================

Name: program_loader

Overview:
- Serial-byte boot loader that sits directly upstream of the `computer` top level.
- Consumes a framed byte stream from a UART receiver and writes the payload into program memory starting at the reset vector region (0xF000).
- Holds the CPU in reset while loading; releases it only after a frame with a valid checksum.
- Replaces `$readmemh` preloading on hardware, so the same op_*.hex programs run on the FPGA.

Parameters:
- ADDR_WIDTH, 16, program memory address width.
- DATA_WIDTH, 8, byte width of stream and memory.
- BASE_ADDR, 16'hF000, address of payload byte 0.
- MAX_LEN, 4096, largest accepted payload length in bytes.
- SYNC_BYTE, 8'hA5, frame start marker.
- HOLD_AT_RESET, 1, 1 = CPU held in reset until first good load; 0 = CPU runs from reset until a sync byte arrives.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data valid this cycle; at most one strobe per 2 cycles.
- mem_we  out  1  one-cycle write strobe to program memory.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_wdata  out  DATA_WIDTH  write data.
- cpu_reset_o  out  1  reset to CPU, active high.
- busy_o  out  1  frame in progress.
- done_o  out  1  last frame loaded with good checksum.
- error_o  out  1  last frame rejected.
- byte_count_o  out  16  payload bytes written in current/last frame.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high, port name `reset`. All state changes occur on the posedge of `clk`.
- Reset values:
  - state = IDLE.
  - mem_we = 0, mem_addr = BASE_ADDR, mem_wdata = 0.
  - busy_o = 0, done_o = 0, error_o = 0, byte_count_o = 0.
  - cpu_reset_o = HOLD_AT_RESET.
- Frame format: SYNC, LEN_HI, LEN_LO, LEN payload bytes, CHK.
  - CHK makes the 8-bit sum of all payload bytes plus CHK equal 0x00.
- FSM states: IDLE, LEN_H, LEN_L, DATA, CHK, DONE, ERROR. Transitions occur only on cycles with rx_valid = 1.
  - IDLE: rx_data == SYNC_BYTE → LEN_H; any other byte is ignored.
  - LEN_H: latch len[15:8] → LEN_L.
  - LEN_L: latch len[7:0].
    - len > MAX_LEN → ERROR.
    - len == 0 → CHK.
    - otherwise → DATA.
  - DATA: each byte issues one write.
    - mem_we pulses high for exactly one cycle, the cycle after the rx_valid strobe (registered).
    - mem_addr = BASE_ADDR + index; mem_wdata = byte.
    - sum += byte, mod 256. index and byte_count_o increment.
    - After the len-th byte → CHK.
  - CHK: (sum + rx_data) mod 256 == 0 → DONE, else → ERROR.
  - DONE / ERROR: a SYNC_BYTE restarts loading (→ LEN_H). Other bytes are ignored.
- Restart on SYNC_BYTE (from DONE or ERROR):
  - cpu_reset_o = 1 the next cycle.
  - done_o, error_o, byte_count_o, sum and index clear.
- A SYNC_BYTE value received inside LEN/DATA/CHK is treated as data, not a resync.
- Status outputs:
  - busy_o = 1 in LEN_H, LEN_L, DATA, CHK.
  - done_o = 1 only in DONE. error_o = 1 only in ERROR.
- cpu_reset_o, registered:
  - 1 in LEN_H, LEN_L, DATA, CHK and ERROR.
  - 0 in DONE.
  - In IDLE = HOLD_AT_RESET.
  - Falls exactly one cycle after the CHK byte strobe.
- Address arithmetic is ADDR_WIDTH bits, modulo 2^ADDR_WIDTH. With BASE_ADDR 0xF000 and MAX_LEN 4096, the last write is 0xFFFF and no wrap occurs.
- Memory written before an ERROR is not rolled back.
- Reset asserted mid-frame: FSM returns to IDLE the next edge and any pending mem_we is cancelled. Bytes already written stay in memory.
- rx_valid while reset is high is ignored.

Test Plan:
- Good load: stream 11, A5, 00, 03, 28, 0A, 30, 9E →
  - 0x11 ignored.
  - Writes F000=28, F001=0A, F002=30, each mem_we one cycle wide, one cycle after its strobe.
  - byte_count_o = 3, done_o = 1, cpu_reset_o 1→0 one cycle after the 0x9E strobe.
- Bad checksum: A5, 00, 02, 01, 02, 00 →
  - Both bytes written.
  - error_o = 1, done_o = 0, cpu_reset_o stays 1.
  - A following good frame recovers to DONE.
- Zero length: A5, 00, 00, 00 → no mem_we, DONE, byte_count_o = 0. A5, 00, 00, 01 → ERROR.
- Oversize: A5, 10, 01 (len 4097) → ERROR immediately after the third byte; no writes.
- Mid-load reset and reload:
  - reset after 2 of 3 payload bytes → IDLE, outputs at reset values, no further writes.
  - Reload A5, 00, 01, A5, 5B → F000=A5 (0xA5 treated as data), DONE.
- HOLD_AT_RESET=0: cpu_reset_o = 0 after reset; rises on the first A5 byte; falls after a good CHK.

Source files
------------

// File: rtl/program_loader.sv
// Serial-byte boot loader: parses SYNC/LEN/payload/CHK frames from a UART receiver,
// writes the payload into program memory at BASE_ADDR and gates the CPU reset.
module program_loader #(
  parameter int                    ADDR_WIDTH    = 16,
  parameter int                    DATA_WIDTH    = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = 'hF000,
  parameter int                    MAX_LEN       = 4096,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE     = 'hA5,
  parameter bit                    HOLD_AT_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_reset_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [15:0]           byte_count_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN_H = 3'd1;
  localparam logic [2:0] S_LEN_L = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_CHK   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  logic [2:0]            state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [15:0]           count_q, count_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  cpu_rst_q, cpu_rst_d;

  // Full length as it would be once the low byte currently on rx_data is latched.
  logic [15:0]           len_full;
  logic [DATA_WIDTH-1:0] chk_sum;
  logic [15:0]           count_inc;

  assign len_full  = {len_q[15:8], rx_data[7:0]};
  assign chk_sum   = sum_q + rx_data;
  assign count_inc = count_q + 16'd1;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    sum_d     = sum_q;
    count_d   = count_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cpu_rst_d = cpu_rst_q;

    if (rx_valid) begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = S_LEN_H;
            sum_d   = '0;
            count_d = '0;
          end
        end
        S_LEN_H: begin
          len_d   = {rx_data[7:0], 8'h00};
          state_d = S_LEN_L;
        end
        S_LEN_L: begin
          len_d = len_full;
          if ({16'd0, len_full} > 32'(MAX_LEN)) begin
            state_d = S_ERROR;
          end else if (len_full == 16'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          we_d    = 1'b1;
          addr_d  = BASE_ADDR + ADDR_WIDTH'(count_q);
          wdata_d = rx_data;
          sum_d   = chk_sum;
          count_d = count_inc;
          if (count_inc == len_q) begin
            state_d = S_CHK;
          end
        end
        S_CHK: begin
          state_d = (chk_sum == '0) ? S_DONE : S_ERROR;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // CPU reset follows the state being entered so it changes with the strobe edge.
    case (state_d)
      S_IDLE:  cpu_rst_d = HOLD_AT_RESET;
      S_DONE:  cpu_rst_d = 1'b0;
      default: cpu_rst_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      sum_q     <= '0;
      count_q   <= '0;
      we_q      <= 1'b0;
      addr_q    <= BASE_ADDR;
      wdata_q   <= '0;
      cpu_rst_q <= HOLD_AT_RESET;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      count_q   <= count_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign cpu_reset_o  = cpu_rst_q;
  assign busy_o       = (state_q == S_LEN_H) || (state_q == S_LEN_L) ||
                        (state_q == S_DATA)  || (state_q == S_CHK);
  assign done_o       = (state_q == S_DONE);
  assign error_o      = (state_q == S_ERROR);
  assign byte_count_o = count_q;

endmodule
